// File: rtl/gcd_stream_pkg.sv
// Shared types and constants for the gcd_stream engine.
// Optional feature macro: GCD_STREAM_CYCLES_EN (adds the cycles_o step counter).
package gcd_stream_pkg;

    // Default operand/result width; legal widths are 2..32.
    localparam int DEFAULT_DATA_BITS = 8;

    // Engine state: waiting for operands, subtracting, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_step_dp.sv
// One combinational step of subtractive GCD: flags for the terminating
// cases and the next (x, y) pair with the smaller value taken off the larger.
module gcd_step_dp
    import gcd_stream_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic [DATA_BITS-1:0] x,
    input  logic [DATA_BITS-1:0] y,
    output logic [DATA_BITS-1:0] nx,
    output logic [DATA_BITS-1:0] ny,
    output logic                 x_zero,
    output logic                 y_zero,
    output logic                 eq
);

    // Compare and subtract; the comparison guard keeps the difference non-negative.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        nx     = x;
        ny     = y;
        x_zero = (x == '0);
        y_zero = (y == '0);
        eq     = (x == y);
        if (x > y) begin
            nx = x - y;
        end else if (y > x) begin
            ny = y - x;
        end
    end

endmodule

// File: rtl/gcd_stream.sv
// Handshaked GCD engine: accepts (x, y) on a valid/ready channel, iterates one
// subtraction per cycle and presents the result on a valid/ready channel.
// Optional feature macro: GCD_STREAM_CYCLES_EN adds cycles_o, the number of
// CALC cycles spent on the current result.
module gcd_stream
    import gcd_stream_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATA_BITS-1:0] x_i,
    input  logic [DATA_BITS-1:0] y_i,
    input  logic                 abort_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_BITS-1:0] result_o,
`ifdef GCD_STREAM_CYCLES_EN
    output logic [DATA_BITS:0]   cycles_o,
`endif
    output logic                 busy_o
);

    gcd_state_e           state;
    logic [DATA_BITS-1:0] x_q;
    logic [DATA_BITS-1:0] y_q;
    logic [DATA_BITS-1:0] res_q;
    logic [DATA_BITS-1:0] nx;
    logic [DATA_BITS-1:0] ny;
    logic                 x_zero;
    logic                 y_zero;
    logic                 eq;
`ifdef GCD_STREAM_CYCLES_EN
    logic [DATA_BITS:0]   cycles_q;
`endif

    gcd_step_dp #(
        .DATA_BITS(DATA_BITS)
    ) u_step (
        .x      (x_q),
        .y      (y_q),
        .nx     (nx),
        .ny     (ny),
        .x_zero (x_zero),
        .y_zero (y_zero),
        .eq     (eq)
    );

    // Handshake outputs come straight from the registered state.
    assign in_ready_o  = (state == IDLE);
    assign busy_o      = (state == CALC);
    assign out_valid_o = (state == DONE);
    assign result_o    = res_q;
`ifdef GCD_STREAM_CYCLES_EN
    assign cycles_o    = cycles_q;
`endif

    // FSM and operand/result registers: capture, iterate, hold until consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            x_q   <= '0;
            y_q   <= '0;
            res_q <= '0;
`ifdef GCD_STREAM_CYCLES_EN
            cycles_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        x_q   <= x_i;
                        y_q   <= y_i;
                        state <= CALC;
`ifdef GCD_STREAM_CYCLES_EN
                        cycles_q <= '0;
`endif
                    end
                end
                CALC: begin
`ifdef GCD_STREAM_CYCLES_EN
                    cycles_q <= cycles_q + 1'b1;
`endif
                    if (abort_i) begin
                        state <= IDLE;
`ifdef GCD_STREAM_CYCLES_EN
                        cycles_q <= '0;
`endif
                    end else if (x_zero) begin
                        res_q <= y_q;
                        state <= DONE;
                    end else if (y_zero) begin
                        res_q <= x_q;
                        state <= DONE;
                    end else if (eq) begin
                        res_q <= x_q;
                        state <= DONE;
                    end else begin
                        x_q <= nx;
                        y_q <= ny;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_stream.sv
// Self-checking bench for gcd_stream (DATA_BITS = 8). A Euclid-based model
// predicts result and timing for every accepted pair; a negedge monitor
// compares all handshake outputs every cycle, and directed vectors pin
// hand-computed results and latencies.
module tb_gcd_stream;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;
`ifdef GCD_STREAM_CYCLES_EN
    logic [W:0]   cycles;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    gcd_stream #(
        .DATA_BITS(W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .x_i         (x),
        .y_i         (y),
        .abort_i     (abort),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
`ifdef GCD_STREAM_CYCLES_EN
        .cycles_o    (cycles),
`endif
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtractive steps = sum of Euclid quotients minus one (zero if an operand is 0).
    function automatic int ref_steps(input int a, input int b);
        int s, t;
        if (a == 0 || b == 0) return 0;
        s = 0;
        while (b != 0) begin
            s += a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return s - 1;
    endfunction

    typedef struct {
        logic [W-1:0] res;
        int           steps;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic pend, exp_ov, exp_busy;

    // Compare process: every cycle, outputs must follow the model's timeline.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 1);
            check("rst_busy", busy, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_result", result, 0);
            sb.delete();
        end else begin
            pend     = 1'b0;
            exp_ov   = 1'b0;
            if (sb.size() > 0) begin
                pend   = (cyc >= sb[0].acc);
                exp_ov = pend && (cyc >= sb[0].acc + sb[0].steps + 1);
            end
            exp_busy = pend && !exp_ov;
            check("mon_in_ready", in_ready, !pend);
            check("mon_busy", busy, exp_busy);
            check("mon_out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                check("mon_result", result, sb[0].res);
`ifdef GCD_STREAM_CYCLES_EN
                check("mon_cycles", cycles, sb[0].steps + 1);
`endif
            end
            if (exp_ov && out_ready) void'(sb.pop_front());
            if (exp_busy && abort) void'(sb.pop_front());
            if (!pend && in_valid) begin
                e.res   = W'(ref_gcd(int'(x), int'(y)));
                e.steps = ref_steps(int'(x), int'(y));
                e.acc   = cyc + 1;
                sb.push_back(e);
            end
        end
    end

    // ---------------- directed helper ----------------
    task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] er, input int elat,
                            input int hold, input int ebusy);
        int lat, nbusy;
        @(posedge clk); #1;
        check("pre_in_ready", in_ready, 1);
        x = a; y = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = '1; y = '1;
        lat = 0; nbusy = 0;
        while (!out_valid && lat < 2000) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        check("dir_latency", lat, elat);
        check("dir_result", result, er);
        if (ebusy >= 0) check("dir_busy_cycles", nbusy, ebusy);
`ifdef GCD_STREAM_CYCLES_EN
        check("dir_cycles", cycles, elat);
`endif
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_result", result, er);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0: return W'($urandom_range(0, 255));
            1: return W'($urandom_range(0, 15));
            2: return W'(6 * $urandom_range(0, 40));
            default: return W'($urandom_range(0, 1) * $urandom_range(1, 255));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int  budget;
        bit  drv_done;
        rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0;
        abort = 1'b0; out_ready = 1'b0;
        #2;
        check("init_in_ready", in_ready, 1);
        check("init_out_valid", out_valid, 0);
        check("init_busy", busy, 0);
        check("init_result", result, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset while in CALC with (12,8).
        @(posedge clk); #1;
        x = 8'd12; y = 8'd8; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("calc_busy", busy, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_result", result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);

        // Directed results and latencies (latency = steps + 1).
        run_pair(8'd12,  8'd8,  8'd4, 3,   0, 3);
        run_pair(8'd0,   8'd9,  8'd9, 1,   0, 1);
        run_pair(8'd9,   8'd0,  8'd9, 1,   0, 1);
        run_pair(8'd0,   8'd0,  8'd0, 1,   0, 1);
        run_pair(8'd7,   8'd7,  8'd7, 1,   0, 1);
        run_pair(8'd255, 8'd1,  8'd1, 255, 0, 255);
        run_pair(8'd18,  8'd27, 8'd9, 3,  10, 3);

        // Abort on the 2nd CALC cycle of (255,1).
        @(posedge clk); #1;
        x = 8'd255; y = 8'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_result", out_valid, 0);
        end
        run_pair(8'd6, 8'd4, 8'd2, 3, 0, 3);

        // Random pairs with random input gaps and output backpressure.
        drv_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk); #1;
                    end
                    x = pick(); y = pick(); in_valid = 1'b1;
                    budget = 0;
                    while (!in_ready && budget < 5000) begin
                        @(posedge clk); #1;
                        budget++;
                    end
                    if (budget >= 5000) check("rand_accept_timeout", 1, 0);
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        budget = 0;
        while (sb.size() > 0 && budget < 5000) begin
            @(posedge clk); #1;
            budget++;
        end
        check("rand_drain", sb.size(), 0);
        out_ready = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
